// File: rtl/boa_insn_realign_pkg.sv
// -----------------------------------------------------------------------------
// boa_insn_realign_pkg
// Shared types and helpers for the instruction realigner.
//   realign_state_e : realigner state (EMPTY / LO / HI / SPLIT)
//   is_rvc()        : true when a parcel's low two bits mark a compressed insn
// -----------------------------------------------------------------------------
package boa_insn_realign_pkg;

    typedef enum logic [1:0] {
        RA_EMPTY = 2'd0,  // no fetch word held
        RA_LO    = 2'd1,  // next insn starts at held[15:0]
        RA_HI    = 2'd2,  // next insn starts at held[31:16]
        RA_SPLIT = 2'd3   // held[31:16] is the low half of a 32-bit insn
    } realign_state_e;

    function automatic logic is_rvc(input logic [1:0] parcel_lsb);
        return parcel_lsb != 2'b11;
    endfunction

endpackage

// File: rtl/boa_insn_realign.sv
// -----------------------------------------------------------------------------
// boa_insn_realign
// Turns a stream of aligned 32-bit little-endian fetch words into a stream of
// instructions, splitting out 16-bit compressed parcels and stitching 32-bit
// instructions that straddle two fetch words.
//
// Configuration macro: BOA_REALIGN_RVC_EN
//   defined   : compressed (RVC) parcels are recognised; all four states used.
//   undefined : every word is one 32-bit insn; only EMPTY and LO are used,
//               o_rvc is 0 and flush_addr[1] is ignored.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   flush, flush_addr  : discard held state, restart at flush_addr (bit 1
//                        selects the starting halfword)
//   f_valid/f_ready    : fetch word handshake; f_data word, f_addr its address
//   o_valid/o_ready    : instruction handshake; o_insn, o_addr, o_rvc
// -----------------------------------------------------------------------------
module boa_insn_realign
    import boa_insn_realign_pkg::*;
#(
    parameter int alen = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [alen-1:0] flush_addr,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [31:0]     f_data,
    input  logic [alen-1:0] f_addr,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [31:0]     o_insn,
    output logic [alen-1:0] o_addr,
    output logic            o_rvc
);

    realign_state_e  state_q, state_d;
    logic [31:0]     held_q, held_d;
    logic [alen-1:0] held_addr_q, held_addr_d;
    logic            f_acc;
    logic            o_xfer;

`ifdef BOA_REALIGN_RVC_EN
    logic            start_hi_q, start_hi_d;
    logic [alen-1:0] hi_addr;

    assign hi_addr = held_addr_q + alen'(2);
`endif

    // The restart address only matters through bit 1; the actual instruction
    // addresses always come from f_addr of the next accepted word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{flush_addr, f_addr[1:0]};

    // Handshake and presented instruction
    always_comb begin
        f_ready = 1'b0;
        o_valid = 1'b0;
        o_insn  = '0;
        o_addr  = '0;
        o_rvc   = 1'b0;
        case (state_q)
            RA_EMPTY: f_ready = 1'b1;
            RA_LO: begin
                o_valid = 1'b1;
                o_addr  = held_addr_q;
`ifdef BOA_REALIGN_RVC_EN
                if (is_rvc(held_q[1:0])) begin
                    // The upper half is still pending, so no new word yet.
                    o_insn = {16'h0000, held_q[15:0]};
                    o_rvc  = 1'b1;
                end else begin
                    o_insn  = held_q;
                    f_ready = o_ready;
                end
`else
                o_insn  = held_q;
                f_ready = o_ready;
`endif
            end
`ifdef BOA_REALIGN_RVC_EN
            RA_HI: begin
                if (is_rvc(held_q[17:16])) begin
                    o_valid = 1'b1;
                    o_insn  = {16'h0000, held_q[31:16]};
                    o_addr  = hi_addr;
                    o_rvc   = 1'b1;
                    f_ready = o_ready;
                end
            end
            RA_SPLIT: begin
                // Upper half comes straight from the incoming word, so the
                // instruction and the word transfer in the same cycle.
                o_valid = f_valid;
                o_insn  = {f_data[15:0], held_q[31:16]};
                o_addr  = hi_addr;
                f_ready = o_ready;
            end
`endif
            default: ;
        endcase
        if (rst) begin
            f_ready = 1'b0;
            o_valid = 1'b0;
            o_insn  = '0;
            o_addr  = '0;
            o_rvc   = 1'b0;
        end else if (flush) begin
            f_ready = 1'b0;
            o_valid = 1'b0;
        end
    end

    assign f_acc  = f_valid && f_ready;
    assign o_xfer = o_valid && o_ready;

    // Next state; every accepted word is latched regardless of state.
    always_comb begin
        state_d     = state_q;
        held_d      = f_acc ? f_data : held_q;
        held_addr_d = f_acc ? {f_addr[alen-1:2], 2'b00} : held_addr_q;
`ifdef BOA_REALIGN_RVC_EN
        start_hi_d  = start_hi_q;
`endif
        case (state_q)
            RA_EMPTY: begin
                if (f_acc) begin
`ifdef BOA_REALIGN_RVC_EN
                    state_d    = start_hi_q ? RA_HI : RA_LO;
                    start_hi_d = 1'b0;
`else
                    state_d    = RA_LO;
`endif
                end
            end
            RA_LO: begin
                if (o_xfer) state_d = f_acc ? RA_LO : RA_EMPTY;
`ifdef BOA_REALIGN_RVC_EN
                if (o_xfer && o_rvc) state_d = RA_HI;
`endif
            end
`ifdef BOA_REALIGN_RVC_EN
            RA_HI: begin
                if (!is_rvc(held_q[17:16])) state_d = RA_SPLIT;
                else if (o_xfer)            state_d = f_acc ? RA_LO : RA_EMPTY;
            end
            RA_SPLIT: begin
                if (o_xfer) state_d = RA_HI;
            end
`endif
            default: state_d = RA_EMPTY;
        endcase
        if (flush) begin
            state_d    = RA_EMPTY;
`ifdef BOA_REALIGN_RVC_EN
            start_hi_d = flush_addr[1];
`endif
        end
    end

    // Control state is reset; the held word is simply orphaned by EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RA_EMPTY;
`ifdef BOA_REALIGN_RVC_EN
            start_hi_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
`ifdef BOA_REALIGN_RVC_EN
            start_hi_q <= start_hi_d;
`endif
        end
        held_q      <= held_d;
        held_addr_q <= held_addr_d;
    end

endmodule

// File: tb/tb_boa_insn_realign.sv
// -----------------------------------------------------------------------------
// tb_boa_insn_realign
// Self-checking bench for boa_insn_realign. Expectations follow the build
// configuration selected by BOA_REALIGN_RVC_EN.
// -----------------------------------------------------------------------------
module tb_boa_insn_realign;

`ifdef BOA_REALIGN_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_addr;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_data;
    logic [31:0] f_addr;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_insn;
    logic [31:0] o_addr;
    logic        o_rvc;

    int checks   = 0;
    int failures = 0;

    boa_insn_realign #(.alen(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_addr (flush_addr),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_data     (f_data),
        .f_addr     (f_addr),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_insn     (o_insn),
        .o_addr     (o_addr),
        .o_rvc      (o_rvc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stream driver and output capture
    // ------------------------------------------------------------------
    logic [31:0] in_w[$];
    logic [31:0] in_a[$];
    logic [31:0] cap_insn[$];
    logic [31:0] cap_addr[$];
    bit          cap_rvc[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush      = 1'b1;
        flush_addr = a;
        f_valid    = 1'b0;
        o_ready    = 1'b1;
        step();
        flush      = 1'b0;
    endtask

    task automatic run_stream(input int budget, output bit timed_out);
        int idx  = 0;
        int idle = 0;
        int cyc  = 0;
        cap_insn.delete();
        cap_addr.delete();
        cap_rvc.delete();
        timed_out = 1'b0;
        o_ready   = 1'b1;
        while (idle < 4 && !timed_out) begin
            f_valid = (idx < in_w.size());
            f_data  = f_valid ? in_w[idx] : 32'h0;
            f_addr  = f_valid ? in_a[idx] : 32'h0;
            @(negedge clk);
            if (o_valid && o_ready) begin
                cap_insn.push_back(o_insn);
                cap_addr.push_back(o_addr);
                cap_rvc.push_back(o_rvc);
            end
            if (f_valid && f_ready) idx++;
            idle = (idx >= in_w.size() && !o_valid) ? idle + 1 : 0;
            cyc++;
            if (cyc > budget) timed_out = 1'b1;
            step();
        end
        f_valid = 1'b0;
    endtask

    // Bring the realigner to the point where the high half of 0x00934085 is
    // held waiting for its upper half (RVC build), or a held 32-bit word.
    task automatic goto_split();
        bit acc;
        bit xf;
        do_flush(32'h300);
        f_valid = 1'b1;
        f_data  = 32'h00934085;
        f_addr  = 32'h300;
        o_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            acc = f_valid && f_ready;
            step();
            if (acc) break;
        end
        f_valid = 1'b0;
        o_ready = RVC_EN;
        for (int k = 0; k < 10 && RVC_EN; k++) begin
            @(negedge clk);
            xf = o_valid && o_ready;
            step();
            if (xf) break;
        end
        o_ready = 1'b0;
        step();
        step();
    endtask

    // ------------------------------------------------------------------
    // Reference model: halfword queue of the fetched stream
    // ------------------------------------------------------------------
    logic [15:0] mq_hw[$];
    logic [31:0] mq_ad[$];
    bit          m_drop;

    function automatic void model_push(input logic [31:0] w, input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        if (!m_drop) begin
            mq_hw.push_back(w[15:0]);
            mq_ad.push_back(base);
        end
        mq_hw.push_back(w[31:16]);
        mq_ad.push_back(base + 32'd2);
        m_drop = 1'b0;
    endfunction

    function automatic bit model_pop(output logic [31:0] insn, output logic [31:0] addr,
                                     output logic rvc);
        logic [15:0] h0;
        insn = 32'h0;
        addr = 32'h0;
        rvc  = 1'b0;
        if (mq_hw.size() == 0) return 1'b0;
        h0   = mq_hw[0];
        addr = mq_ad[0];
        if (RVC_EN && h0[1:0] != 2'b11) begin
            insn = {16'h0000, h0};
            rvc  = 1'b1;
            void'(mq_hw.pop_front());
            void'(mq_ad.pop_front());
            return 1'b1;
        end
        if (mq_hw.size() < 2) return 1'b0;
        insn = {mq_hw[1], h0};
        void'(mq_hw.pop_front());
        void'(mq_ad.pop_front());
        void'(mq_hw.pop_front());
        void'(mq_ad.pop_front());
        return 1'b1;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [15:0] h[2];
        for (int i = 0; i < 2; i++) begin
            h[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) h[i][1:0] = 2'b11;
            else                           h[i][1:0] = 2'($urandom_range(0, 2));
        end
        return {h[1], h[0]};
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        rst        = 1'b1;
        flush      = 1'b1;
        flush_addr = 32'h702;
        f_valid    = 1'b1;
        f_data     = 32'h12345677;
        f_addr     = 32'h700;
        o_ready    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || f_ready !== 1'b0 || o_insn !== 32'h0 ||
                o_addr !== 32'h0 || o_rvc !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got=v%0b r%0b %h@%h c%0b exp=all zero",
                         o_valid, f_ready, o_insn, o_addr, o_rvc);
            end
            step();
        end
        rst     = 1'b0;
        flush   = 1'b0;
        f_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || f_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty got=v%0b r%0b exp=v0 r1", o_valid, f_ready);
        end
        step();
        // rst beat the flush, so the low half of this word is not dropped
        in_w = '{32'h40854501};
        in_a = '{32'h700};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4501, 32'h4085}; ea = '{32'h700, 32'h702}; er = '{1'b1, 1'b1};
        end else begin
            ei = '{32'h40854501}; ea = '{32'h700}; er = '{1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL reset_prec_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL reset_prec_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_aligned32();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        do_flush(32'h100);
        in_w = '{32'h00A00093, 32'h00B00113};
        in_a = '{32'h100, 32'h104};
        run_stream(40, to);
        ei = '{32'h00A00093, 32'h00B00113}; ea = '{32'h100, 32'h104}; er = '{1'b0, 1'b0};
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL aligned32_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL aligned32_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_rvc_pair();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        do_flush(32'h200);
        in_w = '{32'h45014085};
        in_a = '{32'h200};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4085, 32'h4501}; ea = '{32'h200, 32'h202}; er = '{1'b1, 1'b1};
        end else begin
            ei = '{32'h45014085}; ea = '{32'h200}; er = '{1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL rvc_pair_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL rvc_pair_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_split();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        do_flush(32'h300);
        in_w = '{32'h00934085, 32'h4501000A};
        in_a = '{32'h300, 32'h304};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4085, 32'h000A0093, 32'h4501};
            ea = '{32'h300, 32'h302, 32'h306};
            er = '{1'b1, 1'b0, 1'b1};
        end else begin
            ei = '{32'h00934085, 32'h4501000A}; ea = '{32'h300, 32'h304}; er = '{1'b0, 1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL split_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL split_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_flush_hi();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        do_flush(32'h402);
        in_w = '{32'h40854501};
        in_a = '{32'h400};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4085}; ea = '{32'h402}; er = '{1'b1};
        end else begin
            ei = '{32'h40854501}; ea = '{32'h400}; er = '{1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL flush_hi_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL flush_hi_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_split_stall();
        logic [31:0] es, esa, e2, e2a;
        es  = RVC_EN ? 32'h000A0093 : 32'h00934085;
        esa = RVC_EN ? 32'h302 : 32'h300;
        e2  = RVC_EN ? 32'h4501 : 32'h4501000A;
        e2a = RVC_EN ? 32'h306 : 32'h304;
        goto_split();
        f_valid = 1'b1;
        f_data  = 32'h4501000A;
        f_addr  = 32'h304;
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (f_ready !== 1'b0 || o_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hs%0d got=v%0b r%0b exp=v1 r0", k, o_valid, f_ready);
            end
            checks++;
            if (o_insn !== es || o_addr !== esa) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h@%h exp=%h@%h", k, o_insn, o_addr, es, esa);
            end
            step();
        end
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || f_ready !== 1'b1 || o_insn !== es || o_addr !== esa) begin
            failures++;
            $display("FAIL stall_release got=v%0b r%0b %h@%h exp=v1 r1 %h@%h",
                     o_valid, f_ready, o_insn, o_addr, es, esa);
        end
        step();
        f_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_insn !== e2 || o_addr !== e2a) begin
            failures++;
            $display("FAIL stall_next got=v%0b %h@%h exp=v1 %h@%h", o_valid, o_insn, o_addr, e2, e2a);
        end
        step();
    endtask

    task automatic test_flush_split();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        goto_split();
        f_valid    = 1'b1;
        f_data     = 32'h4501000A;
        f_addr     = 32'h304;
        o_ready    = 1'b1;
        flush      = 1'b1;
        flush_addr = 32'h500;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || f_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_split_cycle got=v%0b r%0b exp=v0 r0", o_valid, f_ready);
        end
        step();
        flush   = 1'b0;
        f_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_split_after got=%0b exp=0", o_valid);
        end
        step();
        in_w = '{32'h40854501};
        in_a = '{32'h500};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4501, 32'h4085}; ea = '{32'h500, 32'h502}; er = '{1'b1, 1'b1};
        end else begin
            ei = '{32'h40854501}; ea = '{32'h500}; er = '{1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL flush_split_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL flush_split_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_reset_split();
        bit to;
        logic [31:0] ei[$];
        logic [31:0] ea[$];
        bit          er[$];
        goto_split();
        f_valid = 1'b1;
        f_data  = 32'h4501000A;
        f_addr  = 32'h304;
        o_ready = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || f_ready !== 1'b0 || o_insn !== 32'h0 ||
            o_addr !== 32'h0 || o_rvc !== 1'b0) begin
            failures++;
            $display("FAIL reset_split_cycle got=v%0b r%0b %h@%h c%0b exp=all zero",
                     o_valid, f_ready, o_insn, o_addr, o_rvc);
        end
        step();
        rst     = 1'b0;
        f_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || f_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_split_after got=v%0b r%0b exp=v0 r1", o_valid, f_ready);
        end
        step();
        in_w = '{32'h40854501};
        in_a = '{32'h600};
        run_stream(40, to);
        if (RVC_EN) begin
            ei = '{32'h4501, 32'h4085}; ea = '{32'h600, 32'h602}; er = '{1'b1, 1'b1};
        end else begin
            ei = '{32'h40854501}; ea = '{32'h600}; er = '{1'b0};
        end
        checks++;
        if (to || cap_insn.size() != ei.size()) begin
            failures++;
            $display("FAIL reset_split_count got=%0d exp=%0d timeout=%0b", cap_insn.size(), ei.size(), to);
        end
        for (int i = 0; i < ei.size() && i < cap_insn.size(); i++) begin
            checks++;
            if (cap_insn[i] !== ei[i] || cap_addr[i] !== ea[i] || cap_rvc[i] !== er[i]) begin
                failures++;
                $display("FAIL reset_split_out%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b",
                         i, cap_insn[i], cap_addr[i], cap_rvc[i], ei[i], ea[i], er[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] naddr, pend_w, ei, ea;
        logic        er;
        bit          ok;
        bit          have_word = 1'b0;
        int          nout = 0;
        naddr  = 32'h0;
        pend_w = 32'h0;
        for (int c = 0; c < 1800; c++) begin
            flush = (c == 0) || ($urandom_range(0, 39) == 0);
            if (flush)
                flush_addr = 32'h1000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 1)) * 2;
            if (!have_word) begin
                pend_w    = rand_word();
                have_word = 1'b1;
            end
            f_valid = ($urandom_range(0, 9) < 7);
            f_data  = pend_w;
            f_addr  = naddr;
            o_ready = (c >= 1790) || ($urandom_range(0, 9) < 7);
            if (c >= 1790) f_valid = 1'b0;
            @(negedge clk);
            if (flush) begin
                checks++;
                if (o_valid !== 1'b0 || f_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_flush c%0d got=v%0b r%0b exp=v0 r0", c, o_valid, f_ready);
                end
                mq_hw.delete();
                mq_ad.delete();
                m_drop = RVC_EN && flush_addr[1];
                naddr  = {flush_addr[31:2], 2'b00};
            end else begin
                if (f_valid && f_ready) begin
                    model_push(f_data, f_addr);
                    naddr     = naddr + 32'd4;
                    have_word = 1'b0;
                end
                if (o_valid && o_ready) begin
                    ok = model_pop(ei, ea, er);
                    nout++;
                    checks++;
                    if (!ok || o_insn !== ei || o_addr !== ea || o_rvc !== er) begin
                        failures++;
                        $display("FAIL rand_out c%0d got=%h@%h rvc=%0b exp=%h@%h rvc=%0b model_ok=%0b",
                                 c, o_insn, o_addr, o_rvc, ei, ea, er, ok);
                    end
                end
            end
            step();
        end
        flush = 1'b0;
        checks++;
        if (!(mq_hw.size() == 0 ||
              (RVC_EN && mq_hw.size() == 1 && mq_hw[0][1:0] == 2'b11))) begin
            failures++;
            $display("FAIL rand_drain got=%0d halfwords left exp=0 or one split half", mq_hw.size());
        end
        checks++;
        if (nout < 200) begin
            failures++;
            $display("FAIL rand_progress got=%0d outputs exp>=200", nout);
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        flush_addr = 32'h0;
        f_valid    = 1'b0;
        f_data     = 32'h0;
        f_addr     = 32'h0;
        o_ready    = 1'b0;
        m_drop     = 1'b0;
        test_reset();
        test_aligned32();
        test_rvc_pair();
        test_split();
        test_flush_hi();
        test_split_stall();
        test_flush_split();
        test_reset_split();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
